// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared fetch/decode constants, state encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam logic [1:0]  c_st_wait   = 2'd0;
  localparam logic [1:0]  c_st_boot   = 2'd1;
  localparam logic [1:0]  c_st_run    = 2'd2;
  localparam logic [1:0]  c_st_halted = 2'd3;

  localparam logic [31:0] c_nop_instr = 32'h0000_0000;
  localparam logic [31:0] c_reset_pc  = 32'h0010_0000;

  typedef enum logic [1:0] {
    S_WAIT   = c_st_wait,
    S_BOOT   = c_st_boot,
    S_RUN    = c_st_run,
    S_HALTED = c_st_halted
  } fetch_state_t;

  // Instruction fetches are always word aligned; low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with load / bubble / hold controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // Load wins over bubble; with neither asserted the contents hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (load) begin
      r_instr    <= instr_in;
      r_pc_plus4 <= pc_plus4_in;
      r_valid    <= 1'b1;
    end else if (bubble) begin
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
    end
  end

  assign instr    = r_instr;
  assign pc_plus4 = r_pc_plus4;
  assign valid    = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module      : fetch_pc_unit
// Description : Fetch-stage PC owner: boot, stall, redirect, flush and halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_reset_pc,
  parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] start_addr,
  input  logic [31:0] mem_instruction,
  output logic [31:0] read_address,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_fetch_count;
  logic         r_misaligned;

  logic         w_in_run;
  logic         w_load;
  logic         w_bubble;
  logic [31:0]  w_pc_plus4;

  assign w_in_run   = (r_state == S_RUN);
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_load     = w_in_run && !halt && !redirect_valid && !stall;
  // Outside RUN the register is flushed every cycle; a plain stall holds it.
  assign w_bubble   = !w_in_run || halt || redirect_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_WAIT;
      r_pc          <= RESET_PC;
      r_fetch_count <= 32'h0;
      r_misaligned  <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: r_state <= S_BOOT;
        S_BOOT: begin
          r_pc    <= align_word(start_addr);
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (halt) begin
            r_state <= S_HALTED;
          end else if (redirect_valid) begin
            r_pc         <= align_word(redirect_target);
            r_misaligned <= r_misaligned | (redirect_target[1:0] != 2'b00);
          end else if (!stall) begin
            r_pc          <= w_pc_plus4;
            r_fetch_count <= r_fetch_count + 32'd1;
          end
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_WAIT;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (w_load),
    .bubble      (w_bubble),
    .instr_in    (mem_instruction),
    .pc_plus4_in (w_pc_plus4),
    .instr       (if_id_instr),
    .pc_plus4    (if_id_pc_plus4),
    .valid       (if_id_valid)
  );

  assign read_address = r_pc;
  assign fetch_count  = r_fetch_count;
  assign misaligned   = r_misaligned;

endmodule

`default_nettype wire
